// File: rtl/imem_fetch_pkg.sv
// Shared constants for the instruction-fetch memory: NOP word, fault bit
// positions and the MIPS opcodes used when building test programs.
package imem_pkg;

  localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  function automatic logic [31:0] enc_itype(input logic [5:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// Fetch request/response, program-load and fault signals between the core
// (master) and the instruction memory (slave).
interface imem_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
);
  localparam int AW = $clog2(DEPTH);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic [ADDR_W-1:0] rsp_pc;
  logic [1:0]        rsp_fault;
  logic              prog_en;
  logic [AW-1:0]     prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              fault_sticky;

  modport master (
    output req_valid, req_pc, rsp_ready, prog_en, prog_addr, prog_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault, fault_sticky
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready, prog_en, prog_addr, prog_data,
    output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault, fault_sticky
  );

endinterface

// File: rtl/imem_fetch_ram.sv
// Simple dual-port word array: synchronous write, registered read with read
// enable so the output holds between reads (block-RAM friendly, no reset).
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch memory: one-cycle valid/ready fetch, run-time program
// load, and misaligned/out-of-range detection that substitutes a NOP.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_fetch_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  function automatic logic [1:0] calc_fault(input logic [ADDR_W-1:0] pc);
    logic [1:0] f;
    f                 = 2'b00;
    f[FAULT_MISALIGN] = (pc[1:0] != 2'b00);
    f[FAULT_RANGE]    = ((pc >> (AW + 2)) != '0);
    return f;
  endfunction

  logic              accept_p0;
  logic [1:0]        fault_p0;
  logic [AW-1:0]     idx_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic [1:0]        fault_p1;
  logic              data_ok_p1;
  logic              sticky_p1;
  logic [DATA_W-1:0] rdata_p1;

  // Stage p0: handshake and fault classification of the incoming PC
  assign bus.req_ready = !bus.prog_en && (!vld_p1 || bus.rsp_ready);
  assign accept_p0     = bus.req_valid && bus.req_ready;
  assign fault_p0      = calc_fault(bus.req_pc);
  assign idx_p0        = bus.req_pc[AW+1:2];

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (bus.prog_en),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .re    (accept_p0),
    .raddr (idx_p0),
    .rdata (rdata_p1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      pc_p1      <= '0;
      fault_p1   <= 2'b00;
      data_ok_p1 <= 1'b0;
      sticky_p1  <= 1'b0;
    end else if (accept_p0) begin
      vld_p1     <= 1'b1;
      pc_p1      <= bus.req_pc;
      fault_p1   <= fault_p0;
      data_ok_p1 <= (fault_p0 == 2'b00);
      if (fault_p0 != 2'b00) sticky_p1 <= 1'b1;
    end else if (bus.rsp_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage p1: response; the RAM word is masked to NOP after a fault or reset
  assign bus.rsp_valid    = vld_p1;
  assign bus.rsp_pc       = pc_p1;
  assign bus.rsp_fault    = fault_p1;
  assign bus.rsp_instr    = data_ok_p1 ? rdata_p1 : DATA_W'(IMEM_NOP);
  assign bus.fault_sticky = sticky_p1;

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: a reference model predicts req_ready and
// queues expected responses, which are compared while the DUT presents them.
module tb_imem_fetch;
  import imem_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int AW     = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [1:0]        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  imem_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  logic [DATA_W-1:0] mem_model [DEPTH];
  logic m_vld    = 1'b0;
  logic m_sticky = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [ADDR_W-1:0] pc);
    exp_t e;
    e.pc       = pc;
    e.fault[0] = (pc[1:0] != 2'b00);
    e.fault[1] = ((pc / 4) >= DEPTH);
    e.instr    = (e.fault != 2'b00) ? 32'h0 : mem_model[pc[AW+1:2]];
    return e;
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input string tag);
    logic m_ready;
    exp_t e;
    #1;
    m_ready = !bus.prog_en && (!m_vld || bus.rsp_ready);
    chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(m_ready));
    if (m_vld && bus.rsp_ready && sb.size() > 0) void'(sb.pop_front());
    if (bus.req_valid && m_ready) begin
      e = predict(bus.req_pc);
      sb.push_back(e);
      if (e.fault != 2'b00) m_sticky = 1'b1;
      m_vld = 1'b1;
    end else if (bus.rsp_ready) begin
      m_vld = 1'b0;
    end
    if (bus.prog_en) mem_model[bus.prog_addr] = bus.prog_data;
    @(negedge clk);
    chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(m_vld));
    chk({tag, ".sticky"}, 64'(bus.fault_sticky), 64'(m_sticky));
    if (m_vld) begin
      if (sb.size() == 0) begin
        chk({tag, ".sb_empty"}, 64'(1), 64'(0));
      end else begin
        chk({tag, ".rsp_instr"}, 64'(bus.rsp_instr), 64'(sb[0].instr));
        chk({tag, ".rsp_pc"}, 64'(bus.rsp_pc), 64'(sb[0].pc));
        chk({tag, ".rsp_fault"}, 64'(bus.rsp_fault), 64'(sb[0].fault));
      end
    end
  endtask

  task automatic drive(input logic rv, input logic [ADDR_W-1:0] pc, input logic rr,
                       input logic pe, input logic [AW-1:0] pa, input logic [DATA_W-1:0] pd);
    bus.req_valid = rv;
    bus.req_pc    = pc;
    bus.rsp_ready = rr;
    bus.prog_en   = pe;
    bus.prog_addr = pa;
    bus.prog_data = pd;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst.rsp_fault", 64'(bus.rsp_fault), 64'(0));
    chk("rst.rsp_instr", 64'(bus.rsp_instr), 64'(0));
    chk("rst.rsp_pc", 64'(bus.rsp_pc), 64'(0));
    chk("rst.sticky", 64'(bus.fault_sticky), 64'(0));
    rst_n = 1'b1;

    // Program load, then back-to-back fetch
    drive(1'b0, '0, 1'b1, 1'b1, AW'(1), enc_itype(OP_ADDI, 5'd0, 5'd8, 16'd10));
    step("load1");
    drive(1'b0, '0, 1'b1, 1'b1, AW'(2), 32'h2009000F);
    step("load2");
    drive(1'b1, 32'd4, 1'b1, 1'b0, '0, '0);
    step("stream4");
    chk("stream4.addi", 64'(bus.rsp_instr), 64'h2008000A);
    drive(1'b1, 32'd8, 1'b1, 1'b0, '0, '0);
    step("stream8");
    chk("stream8.word", 64'(bus.rsp_instr), 64'h2009000F);
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    step("idle1");

    // Consumer stall for three cycles with a new request waiting
    drive(1'b1, 32'd4, 1'b1, 1'b0, '0, '0);
    step("stall_pre");
    drive(1'b1, 32'd8, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i));
    drive(1'b1, 32'd8, 1'b1, 1'b0, '0, '0);
    step("stall_rel");
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    step("idle2");

    // Faulting PCs: misaligned, out of range, both
    drive(1'b1, 32'd6, 1'b1, 1'b0, '0, '0);
    step("f_mis");
    drive(1'b1, 32'(4 * DEPTH), 1'b1, 1'b0, '0, '0);
    step("f_rng");
    drive(1'b1, 32'(4 * DEPTH + 2), 1'b1, 1'b0, '0, '0);
    step("f_both");
    chk("f_both.bits", 64'(bus.rsp_fault), 64'(2'b11));
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    step("idle3");

    // Write cycle blocks fetch; the next cycle sees the new word
    drive(1'b1, 32'd12, 1'b1, 1'b1, AW'(3), 32'h11090004);
    step("wr_blk");
    drive(1'b1, 32'd12, 1'b1, 1'b0, '0, '0);
    step("wr_fetch");
    chk("wr_fetch.word", 64'(bus.rsp_instr), 64'h11090004);
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    step("idle4");

    // Asynchronous reset while a response is stalled
    drive(1'b1, 32'd4, 1'b0, 1'b0, '0, '0);
    step("ar_acc");
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step("ar_hold");
    #2 rst_n = 1'b0;
    #1;
    chk("ar.rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("ar.sticky", 64'(bus.fault_sticky), 64'(0));
    chk("ar.rsp_fault", 64'(bus.rsp_fault), 64'(0));
    m_vld    = 1'b0;
    m_sticky = 1'b0;
    sb.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'd4, 1'b1, 1'b0, '0, '0);
    step("ar_fetch");
    chk("ar_fetch.addi", 64'(bus.rsp_instr), 64'h2008000A);
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    step("idle5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
